beam_delay_sched: RTL and testbench
===================================

Name: beam_delay_sched

Overview:
- Controller that sequences steering updates for the bank of per-channel programmable I/Q delay lines in the beamformer front end.
- Holds a beam-by-channel delay table and accepts a beam-switch request over a valid/ready handshake.
- Waits for a frame boundary, then writes each channel's delay into the delay lines one channel per cycle.
- Blanks the combiner output until the longest delay line has refilled, then reports completion.

Parameters:
- N_CH, 4, number of antenna channels / delay lines.
- CW, 2, channel index width; N_CH <= 2**CW.
- DW, 4, delay value width in samples (0..15).
- BW, 3, beam index width; the number of beams N_BEAM = 2**BW is a localparam.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous reset, active-high.
- tbl_we  in  1  delay table write strobe.
- tbl_beam  in  BW  table write beam index.
- tbl_ch  in  CW  table write channel index.
- tbl_delay  in  DW  table write data.
- req_valid  in  1  beam-switch request valid.
- req_beam  in  BW  requested beam index.
- req_ready  out  1  request can be accepted.
- frame_sync  in  1  one-cycle frame-boundary pulse.
- dly_we  out  1  delay-line configuration write strobe.
- dly_ch  out  CW  target channel for dly_val.
- dly_val  out  DW  delay value for dly_ch.
- out_blank  out  1  mute combiner output while delay lines refill.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse when the switch completes.
- cur_beam  out  BW  beam currently in effect.

Behaviour:
- Reset (synchronous, rst=1 at a posedge):
  - state=IDLE; all table entries=0.
  - req_ready=1 from the first cycle after rst deasserts; all other outputs=0, including cur_beam.
  - Reset mid-operation aborts immediately. No further dly_we is issued, and out_blank drops in the cycle after the reset edge.
- Table:
  - N_BEAM*N_CH registers, written on tbl_we in any state.
  - A write takes effect from the next cycle. A read in the same cycle returns the old value.
  - tbl_ch >= N_CH is ignored.
- States: IDLE, WAIT_SYNC, LOAD, SETTLE, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready, capture req_beam into tgt_beam and go to WAIT_SYNC.
  - frame_sync in the accept cycle is ignored.
- WAIT_SYNC:
  - req_ready=0.
  - Stay until frame_sync=1; on frame_sync, clear ch counter k=0 and maxd=0, then go to LOAD.
- LOAD: lasts exactly N_CH cycles.
  - Each cycle: dly_we=1, dly_ch=k, dly_val=tbl[tgt_beam][k].
  - maxd is updated to max(maxd, dly_val); k increments.
  - After k=N_CH-1, load cnt=the final maxd value, then go to SETTLE.
- SETTLE:
  - Holds for maxd+1 cycles, counting cnt down to 0.
  - Then go to DONE.
- DONE:
  - Lasts one cycle: done=1, cur_beam<=tgt_beam (visible from the next cycle).
  - Then go to IDLE.
- out_blank is 1 in every LOAD, SETTLE and DONE cycle, and 0 otherwise.
- Timing: if frame_sync is sampled high in cycle s:
  - LOAD occupies s+1..s+N_CH.
  - SETTLE occupies s+N_CH+1..s+N_CH+maxd+1.
  - DONE is at s+N_CH+maxd+2.
- Outputs dly_we/dly_ch/dly_val/done/out_blank are registered or state-decoded, with no combinational path from inputs.
  - dly_ch and dly_val hold 0 when dly_we=0.
- frame_sync and req_valid are ignored outside WAIT_SYNC and IDLE respectively.
- A request for the beam already in effect is processed normally; there is no short-circuit.

Decomposition:
- Shared package beam_pkg holds:
  - the localparams N_CH, CW, DW, BW, N_BEAM;
  - the state encoding enum (IDLE=0, WAIT_SYNC=1, LOAD=2, SETTLE=3, DONE=4).
- One natural sub-module: beam_delay_tbl, the register-file table with one write port and one combinational read port.

Test Plan:
- Reset: rst=1 for 2 cycles -> all outputs 0, table reads 0; req_ready=1 in the first cycle after release.
- Basic switch:
  - Stimulus: load beam 3 with delays {2,5,1,0}; request beam 3; frame_sync 4 cycles after accept.
  - Response: LOAD writes (ch0,2),(ch1,5),(ch2,1),(ch3,0) on consecutive cycles; SETTLE lasts 6 cycles; done at s+11; cur_beam=3; out_blank high for exactly 11 cycles.
- All-zero beam:
  - Stimulus: request beam 0 after reset.
  - Response: SETTLE is 1 cycle; done at s+6.
- Table write collision:
  - Stimulus: during the LOAD cycle for ch1, write tbl[3][1]=9.
  - Response: dly_val=5 (old value) is issued; a subsequent request for beam 3 writes 9 and SETTLE is 10 cycles.
- Ignored events:
  - Stimulus: frame_sync in the accept cycle and during SETTLE; req_valid held high while busy.
  - Response: no restart, req_ready=0 while busy, exactly one done pulse per accepted request.
- Reset mid-operation:
  - Stimulus: rst asserted in the second LOAD cycle.
  - Response: from the next cycle, no dly_we, out_blank=0, cur_beam=0, state IDLE, table cleared.

Source files
------------

// File: rtl/beam_pkg.sv
// Shared sizing and state encoding for the beam-switch delay scheduler.
package beam_pkg;

    localparam int N_CH   = 4;
    localparam int CW     = 2;
    localparam int DW     = 4;
    localparam int BW     = 3;
    localparam int N_BEAM = 1 << BW;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_SYNC = 3'd1,
        LOAD      = 3'd2,
        SETTLE    = 3'd3,
        DONE      = 3'd4
    } state_t;

    function automatic logic [DW-1:0] max_dly(input logic [DW-1:0] a, input logic [DW-1:0] b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/beam_delay_tbl.sv
// Beam-by-channel delay register file: one write port, one combinational read port.
module beam_delay_tbl
    import beam_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [BW-1:0] i_wr_beam,
    input  logic [CW-1:0] i_wr_ch,
    input  logic [DW-1:0] i_wr_delay,
    input  logic [BW-1:0] i_rd_beam,
    input  logic [CW-1:0] i_rd_ch,
    output logic [DW-1:0] o_rd_delay
);

    logic [DW-1:0] r_tbl [N_BEAM][N_CH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int b = 0; b < N_BEAM; b++) begin
                for (int c = 0; c < N_CH; c++) begin
                    r_tbl[b][c] <= '0;
                end
            end
        end else if (i_we && (int'(i_wr_ch) < N_CH)) begin
            r_tbl[i_wr_beam][i_wr_ch] <= i_wr_delay;
        end
    end

    // Reads see the registered contents, so a same-cycle write returns the old value.
    assign o_rd_delay = (int'(i_rd_ch) < N_CH) ? r_tbl[i_rd_beam][i_rd_ch] : '0;

endmodule

// File: rtl/beam_delay_sched.sv
// Sequences a beam switch: wait for frame boundary, load each channel's delay, blank until refilled.
module beam_delay_sched
    import beam_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          tbl_we,
    input  logic [BW-1:0] tbl_beam,
    input  logic [CW-1:0] tbl_ch,
    input  logic [DW-1:0] tbl_delay,
    input  logic          req_valid,
    input  logic [BW-1:0] req_beam,
    output logic          req_ready,
    input  logic          frame_sync,
    output logic          dly_we,
    output logic [CW-1:0] dly_ch,
    output logic [DW-1:0] dly_val,
    output logic          out_blank,
    output logic          busy,
    output logic          done,
    output logic [BW-1:0] cur_beam
);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_k;
    logic [DW-1:0] r_maxd;
    logic [DW-1:0] r_cnt;
    logic [BW-1:0] r_tgt;
    logic [BW-1:0] r_cur;
    logic [DW-1:0] w_rd;
    logic [DW-1:0] w_maxd_nxt;
    logic          w_last;

    beam_delay_tbl u_tbl (
        .clk        (clk),
        .rst        (rst),
        .i_we       (tbl_we),
        .i_wr_beam  (tbl_beam),
        .i_wr_ch    (tbl_ch),
        .i_wr_delay (tbl_delay),
        .i_rd_beam  (r_tgt),
        .i_rd_ch    (r_k),
        .o_rd_delay (w_rd)
    );

    assign w_last     = (r_k == CW'(N_CH - 1));
    assign w_maxd_nxt = max_dly(r_maxd, w_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        dly_we    = 1'b0;
        dly_ch    = '0;
        dly_val   = '0;
        out_blank = 1'b0;
        busy      = (r_state != IDLE);
        done      = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = !rst;
                if (req_valid) w_next = WAIT_SYNC;
            end
            WAIT_SYNC: begin
                if (frame_sync) w_next = LOAD;
            end
            LOAD: begin
                dly_we    = 1'b1;
                dly_ch    = r_k;
                dly_val   = w_rd;
                out_blank = 1'b1;
                if (w_last) w_next = SETTLE;
            end
            SETTLE: begin
                out_blank = 1'b1;
                if (r_cnt == '0) w_next = DONE;
            end
            DONE: begin
                out_blank = 1'b1;
                done      = 1'b1;
                w_next    = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Datapath registers are always (re)initialised before use, so only state and cur_beam reset.
    always_ff @(posedge clk) begin
        case (r_state)
            IDLE: begin
                if (req_valid) r_tgt <= req_beam;
            end
            WAIT_SYNC: begin
                if (frame_sync) begin
                    r_k    <= '0;
                    r_maxd <= '0;
                end
            end
            LOAD: begin
                r_k    <= r_k + 1'b1;
                r_maxd <= w_maxd_nxt;
                if (w_last) r_cnt <= w_maxd_nxt;
            end
            SETTLE: begin
                if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cur <= '0;
        end else if (r_state == DONE) begin
            r_cur <= r_tgt;
        end
    end

    assign cur_beam = r_cur;

endmodule

// File: tb/tb_beam_delay_sched.sv
// Bench for beam_delay_sched: vector table, hand sequences and randomized switches vs a table model.
module tb_beam_delay_sched;
    import beam_pkg::*;

    logic          clk = 1'b0;
    logic          rst;
    logic          tbl_we;
    logic [BW-1:0] tbl_beam;
    logic [CW-1:0] tbl_ch;
    logic [DW-1:0] tbl_delay;
    logic          req_valid;
    logic [BW-1:0] req_beam;
    logic          req_ready;
    logic          frame_sync;
    logic          dly_we;
    logic [CW-1:0] dly_ch;
    logic [DW-1:0] dly_val;
    logic          out_blank;
    logic          busy;
    logic          done;
    logic [BW-1:0] cur_beam;

    always #5 clk = ~clk;

    beam_delay_sched dut (
        .clk        (clk),
        .rst        (rst),
        .tbl_we     (tbl_we),
        .tbl_beam   (tbl_beam),
        .tbl_ch     (tbl_ch),
        .tbl_delay  (tbl_delay),
        .req_valid  (req_valid),
        .req_beam   (req_beam),
        .req_ready  (req_ready),
        .frame_sync (frame_sync),
        .dly_we     (dly_we),
        .dly_ch     (dly_ch),
        .dly_val    (dly_val),
        .out_blank  (out_blank),
        .busy       (busy),
        .done       (done),
        .cur_beam   (cur_beam)
    );

    typedef struct {
        int beam;
        int d[N_CH];
        bit load;
        int gap;
        bit noisy;
        int coll;
        int exp_done;
        int exp_blank;
    } vec_t;

    vec_t vecs[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   mtbl[N_BEAM][N_CH];
    int   mcur = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic twrite(input int b, input int c, input int d);
        tbl_we    = 1'b1;
        tbl_beam  = BW'(b);
        tbl_ch    = CW'(c);
        tbl_delay = DW'(d);
        step();
        tbl_we = 1'b0;
        mtbl[b][c] = d;
    endtask

    task automatic add_vec(input int beam, input int d0, input int d1, input int d2, input int d3,
                           input bit load, input int gap, input bit noisy, input int coll,
                           input int exp_done, input int exp_blank);
        vec_t v;
        v.beam = beam;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
        v.load = load; v.gap = gap; v.noisy = noisy; v.coll = coll;
        v.exp_done = exp_done; v.exp_blank = exp_blank;
        vecs.push_back(v);
    endtask

    // One full switch; expectations come from the model table: LOAD writes each channel in order,
    // settle is max delay + 1 cycles, done lands at N_CH + max + 2 cycles after the sync cycle.
    task automatic do_switch(input string tag, input int beam, input int gap, input bit noisy,
                             input int coll, output int done_t, output int blank_n);
        int exp_val[N_CH];
        int maxd, n_wr, bad_wr, bad_rdy;
        maxd = 0;
        for (int c = 0; c < N_CH; c++) begin
            exp_val[c] = mtbl[beam][c];
            if (exp_val[c] > maxd) maxd = exp_val[c];
        end
        chk({tag, " ready_idle"}, int'(req_ready), 1);
        req_valid  = 1'b1;
        req_beam   = BW'(beam);
        frame_sync = noisy;
        step();
        frame_sync = 1'b0;
        if (!noisy) req_valid = 1'b0;
        bad_rdy = 0;
        for (int g = 0; g < gap; g++) begin
            if (req_ready || !busy || out_blank || dly_we) bad_rdy++;
            step();
        end
        frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        done_t = -1; blank_n = 0; n_wr = 0; bad_wr = 0;
        for (int t = 1; t <= 40 && done_t < 0; t++) begin
            if (req_ready || !busy) bad_rdy++;
            if (out_blank) blank_n++;
            if (dly_we) begin
                n_wr++;
                if (t > N_CH) bad_wr++;
                else if (int'(dly_ch) != t - 1 || int'(dly_val) != exp_val[t-1]) bad_wr++;
            end else if (t <= N_CH || dly_ch != '0 || dly_val != '0) begin
                bad_wr++;
            end
            if (done) begin
                done_t    = t;
                req_valid = 1'b0;
            end
            tbl_we = 1'b0;
            if (coll >= 0 && t == 2) begin
                tbl_we = 1'b1; tbl_beam = BW'(beam); tbl_ch = CW'(1); tbl_delay = DW'(coll);
            end
            frame_sync = noisy && (t == N_CH + 1 || t == N_CH + 3);
            step();
            if (coll >= 0 && t == 2) mtbl[beam][1] = coll;
        end
        tbl_we = 1'b0; frame_sync = 1'b0; req_valid = 1'b0;
        chk({tag, " done_t"}, done_t, N_CH + maxd + 2);
        chk({tag, " blank_cycles"}, blank_n, N_CH + maxd + 2);
        chk({tag, " n_writes"}, n_wr, N_CH);
        chk({tag, " bad_writes"}, bad_wr, 0);
        chk({tag, " busy_handshake"}, bad_rdy, 0);
        chk({tag, " cur_beam"}, int'(cur_beam), beam);
        chk({tag, " idle_after"}, int'({busy, done, out_blank, dly_we}), 0);
        mcur = beam;
        step();
        chk({tag, " no_restart"}, int'({busy, done, out_blank}), 0);
    endtask

    initial begin
        int dt, bn;
        rst = 1'b1; tbl_we = 1'b0; tbl_beam = '0; tbl_ch = '0; tbl_delay = '0;
        req_valid = 1'b0; req_beam = '0; frame_sync = 1'b0;
        for (int b = 0; b < N_BEAM; b++)
            for (int c = 0; c < N_CH; c++) mtbl[b][c] = 0;

        add_vec(0, 0, 0, 0, 0, 1'b0, 0, 1'b0, -1, 6, 6);
        add_vec(3, 2, 5, 1, 0, 1'b1, 3, 1'b0, -1, 11, 11);
        add_vec(3, 2, 5, 1, 0, 1'b0, 2, 1'b0, 9, 11, 11);
        add_vec(3, 0, 0, 0, 0, 1'b0, 1, 1'b0, -1, 15, 15);
        add_vec(5, 7, 3, 15, 0, 1'b1, 2, 1'b1, -1, 21, 21);
        add_vec(5, 0, 0, 0, 0, 1'b0, 1, 1'b1, -1, 21, 21);
        add_vec(6, 0, 0, 0, 1, 1'b1, 0, 1'b0, -1, 7, 7);

        step(); step();
        chk("rst_outputs", int'({dly_we, dly_ch, dly_val, out_blank, busy, done, cur_beam}), 0);
        rst = 1'b0;
        #1;
        chk("rst_ready_after_release", int'(req_ready), 1);

        foreach (vecs[i]) begin
            if (vecs[i].load)
                for (int c = 0; c < N_CH; c++) twrite(vecs[i].beam, c, vecs[i].d[c]);
            do_switch($sformatf("vec%0d", i), vecs[i].beam, vecs[i].gap, vecs[i].noisy,
                      vecs[i].coll, dt, bn);
            chk($sformatf("vec%0d tbl_done", i), dt, vecs[i].exp_done);
            chk($sformatf("vec%0d tbl_blank", i), bn, vecs[i].exp_blank);
        end

        // Reset in the second LOAD cycle of a beam-3 switch.
        req_valid = 1'b1; req_beam = BW'(3);
        step();
        req_valid = 1'b0; frame_sync = 1'b1;
        step();
        frame_sync = 1'b0;
        chk("mid_first_load", int'(dly_we), 1);
        step();
        chk("mid_second_load", int'({dly_we, dly_ch}), int'({1'b1, CW'(1)}));
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_outputs", int'({dly_we, out_blank, busy, done, cur_beam}), 0);
        bn = 0;
        for (int i = 0; i < 6; i++) begin
            if (dly_we || out_blank || busy) bn++;
            step();
        end
        chk("mid_rst_quiet", bn, 0);
        for (int b = 0; b < N_BEAM; b++)
            for (int c = 0; c < N_CH; c++) mtbl[b][c] = 0;
        mcur = 0;
        do_switch("post_rst_beam3", 3, 1, 1'b0, -1, dt, bn);
        chk("post_rst_cleared_done", dt, 6);

        for (int it = 0; it < 12; it++) begin
            int nw, beam, gap;
            nw = $urandom_range(1, 6);
            for (int w = 0; w < nw; w++)
                twrite($urandom_range(0, N_BEAM - 1), $urandom_range(0, N_CH - 1),
                       $urandom_range(0, (1 << DW) - 1));
            beam = $urandom_range(0, N_BEAM - 1);
            gap  = $urandom_range(1, 3);
            do_switch($sformatf("rnd%0d", it), beam, gap, 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0) ? $urandom_range(0, (1 << DW) - 1) : -1, dt, bn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
